bsg_scatter_expand: RTL and testbench

//  Sequential inverse of the scatter/gather compaction mapping. Accepts a position mask, then
//  a dense stream of popcount(mask) words. Word k is placed in the slot of the k-th set bit,

---
 rtl/bsg_scatter_expand_pkg.sv | 15 +
 rtl/bsg_scatter_expand_lsb_idx.sv | 29 ++
 rtl/bsg_scatter_expand.sv | 113 +++++++++++
 tb/tb_bsg_scatter_expand.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_scatter_expand_pkg.sv
// Shared types and helpers for the scatter-expand block.
package bsg_scatter_expand_pkg;

    typedef enum logic [1:0] {
        eMask = 2'd0,
        eFill = 2'd1,
        eOut  = 2'd2
    } bsg_scatter_expand_state_e;

    // Index width that stays at least one bit wide for a single slot.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_scatter_expand_lsb_idx.sv
// Lowest-set-bit finder: index of the lowest set bit and an exactly-one-set flag.
module bsg_scatter_expand_lsb_idx
    import bsg_scatter_expand_pkg::*;
#(
    parameter int els_p     = 16,
    parameter int lg_els_lp = safe_clog2(els_p)
) (
    input  logic [els_p-1:0]     v_i,
    output logic [lg_els_lp-1:0] idx_o,
    output logic                 one_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < els_p; i++) begin
            if (v_i[i] && !found) begin
                idx_o = lg_els_lp'(i);
                found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign one_o = (v_i != '0) && ((v_i & (v_i - els_p'(1))) == '0);

endmodule

// File: rtl/bsg_scatter_expand.sv
// Rebuilds a lane-aligned vector from a mask followed by a dense stream of words.
module bsg_scatter_expand
    import bsg_scatter_expand_pkg::*;
#(
    parameter int els_p   = 16,
    parameter int width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       mask_v_i,
    input  logic [els_p-1:0]           mask_i,
    output logic                       mask_ready_o,
    input  logic                       data_v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       data_ready_o,
    output logic                       v_o,
    output logic [els_p*width_p-1:0]   data_o,
    output logic [els_p-1:0]           mask_o,
    input  logic                       yumi_i
);

    localparam int lg_els_lp = safe_clog2(els_p);

    bsg_scatter_expand_state_e state_r, state_n;

    logic [els_p-1:0]     mask_r;
    logic [els_p-1:0]     remain_r;
    logic [width_p-1:0]   buf_r [els_p];
    logic [els_p-1:0]     slot_we;
    logic [lg_els_lp-1:0] idx;
    logic                 last_one;
    logic                 mask_hs;
    logic                 data_hs;

    bsg_scatter_expand_lsb_idx #(
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) lsb_idx (
        .v_i   (remain_r),
        .idx_o (idx),
        .one_o (last_one)
    );

    assign mask_hs = (state_r == eMask) && mask_v_i;
    assign data_hs = (state_r == eFill) && data_v_i;

    always_comb begin
        slot_we = '0;
        if (data_hs) begin
            slot_we[idx] = 1'b1;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            eMask: if (mask_v_i) state_n = (mask_i == '0) ? eOut : eFill;
            eFill: if (data_v_i && last_one) state_n = eOut;
            eOut:  if (yumi_i) state_n = eMask;
            default: state_n = eMask;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= eMask;
            mask_r   <= '0;
            remain_r <= '0;
            for (int unsigned i = 0; i < els_p; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            state_r <= state_n;
            if (mask_hs) begin
                mask_r   <= mask_i;
                remain_r <= mask_i;
            end else if (data_hs) begin
                remain_r <= remain_r & ~slot_we;
            end
            for (int unsigned i = 0; i < els_p; i++) begin
                if (mask_hs) begin
                    buf_r[i] <= '0;
                end else if (slot_we[i]) begin
                    buf_r[i] <= data_i;
                end
            end
        end
    end

    // Outputs are state decodes, forced low while reset is held.
    always_comb begin
        mask_ready_o = !reset_i && (state_r == eMask);
        data_ready_o = !reset_i && (state_r == eFill);
        v_o          = !reset_i && (state_r == eOut);
        data_o       = '0;
        mask_o       = '0;
        if (v_o) begin
            mask_o = mask_r;
            for (int unsigned i = 0; i < els_p; i++) begin
                data_o[i*width_p +: width_p] = buf_r[i];
            end
        end
    end

    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> (state_r == eOut)
    ) else $error("yumi_i asserted while v_o is low");

    a_remain_nonzero_in_fill: assert property (
        @(posedge clk_i) disable iff (reset_i) (state_r == eFill) |-> (remain_r != '0)
    ) else $error("remain_r empty while filling");

endmodule

// File: tb/tb_bsg_scatter_expand.sv
// Randomized scoreboard bench for bsg_scatter_expand against a mask/word expansion model.
module tb_bsg_scatter_expand;

    localparam int ELS = 16;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             mask_v_i;
    logic [ELS-1:0]   mask_i;
    logic             mask_ready_o;
    logic             data_v_i;
    logic [W-1:0]     data_i;
    logic             data_ready_o;
    logic             v_o;
    logic [ELS*W-1:0] data_o;
    logic [ELS-1:0]   mask_o;
    logic             yumi_i;

    bsg_scatter_expand #(
        .els_p   (ELS),
        .width_p (W)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .mask_v_i     (mask_v_i),
        .mask_i       (mask_i),
        .mask_ready_o (mask_ready_o),
        .data_v_i     (data_v_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .yumi_i       (yumi_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ELS-1:0]   m;
        logic [ELS*W-1:0] d;
        int               at;
    } exp_t;

    exp_t       sb[$];
    logic [W-1:0] wq[$];
    int         checks = 0;
    int         errors = 0;
    int         force_hold = -1;

    task automatic chk(input bit ok, input string name,
                       input logic [ELS*W-1:0] act, input logic [ELS*W-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Word k lands in the slot of the k-th set mask bit counted from the LSB.
    function automatic logic [ELS*W-1:0] expand(input logic [ELS-1:0] m, input logic [W-1:0] w[$]);
        logic [ELS*W-1:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < ELS; i++) begin
            if (m[i]) begin
                r[i*W +: W] = w[k];
                k++;
            end
        end
        return r;
    endfunction

    task automatic run_txn(input logic [ELS-1:0] m, input bit gaps, input int abort_at);
        int n, k, t;
        exp_t e;
        n = $countones(m);
        while (wq.size() < n) wq.push_back(W'($urandom));
        mask_v_i = 1'b1;
        mask_i   = m;
        data_v_i = 1'($urandom);
        data_i   = W'($urandom);
        t = 0;
        forever begin
            #1;
            if (mask_ready_o) break;
            @(negedge clk);
            t++;
            if (t > 200) begin
                chk(1'b0, "mask_ready_timeout", 0, 1);
                mask_v_i = 1'b0;
                return;
            end
        end
        e.m  = m;
        e.d  = expand(m, wq);
        e.at = cyc + 1;
        if (n == 0) begin
            sb.push_back(e);
            @(negedge clk);
            mask_v_i = 1'b0;
            #1;
            chk(data_ready_o == 1'b0, "empty_no_data_ready", ELS*W'(data_ready_o), 0);
        end
        k = 0;
        t = 0;
        while (k < n) begin
            @(negedge clk);
            mask_v_i = 1'($urandom);
            mask_i   = ELS'($urandom);
            if (k == abort_at) begin
                reset_i  = 1'b1;
                data_v_i = 1'b1;
                data_i   = W'($urandom);
                #1;
                chk({mask_ready_o, data_ready_o, v_o} == 3'b000, "reset_handshakes_low",
                    ELS*W'({mask_ready_o, data_ready_o, v_o}), 0);
                chk(data_o == '0 && mask_o == '0, "reset_data_mask_zero",
                    data_o ^ ELS*W'(mask_o), 0);
                @(negedge clk);
                reset_i  = 1'b0;
                mask_v_i = 1'b0;
                data_v_i = 1'b0;
                wq.delete();
                return;
            end
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                data_v_i = 1'b0;
                data_i   = W'($urandom);
            end else begin
                data_v_i = 1'b1;
                data_i   = wq[k];
                k++;
                if (k == n) begin
                    e.at = cyc + 1;
                    sb.push_back(e);
                end
            end
            #1;
            chk(data_ready_o == 1'b1, "data_ready_in_fill", ELS*W'(data_ready_o), 1);
            t++;
            if (t > 500) begin
                chk(1'b0, "fill_timeout", 0, 1);
                break;
            end
        end
        if (n != 0) begin
            @(negedge clk);
            mask_v_i = 1'b0;
        end
        data_v_i = 1'($urandom);
        data_i   = W'($urandom);
        wq.delete();
    endtask

    // Monitor: pops the scoreboard whenever a vector is presented, then retires it.
    initial begin
        exp_t e;
        int hold;
        yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!v_o) begin
                chk(data_o == '0 && mask_o == '0, "idle_outputs_zero", data_o ^ ELS*W'(mask_o), 0);
                chk(!(mask_ready_o && data_ready_o), "ready_exclusive",
                    ELS*W'({mask_ready_o, data_ready_o}), 0);
                continue;
            end
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_vector", data_o, 0);
                yumi_i = 1'b1;
                @(negedge clk);
                #2;
                yumi_i = 1'b0;
                continue;
            end
            e = sb.pop_front();
            chk(data_o == e.d, "data_o", data_o, e.d);
            chk(mask_o == e.m, "mask_o", ELS*W'(mask_o), ELS*W'(e.m));
            chk(cyc == e.at, "latency", ELS*W'(cyc), ELS*W'(e.at));
            if (force_hold >= 0) begin
                hold = force_hold;
                force_hold = -1;
            end else begin
                hold = $urandom_range(0, 3);
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #2;
                chk(v_o == 1'b1 && data_o == e.d && mask_o == e.m, "hold_stable", data_o, e.d);
                chk(mask_ready_o == 1'b0, "hold_no_mask_ready", ELS*W'(mask_ready_o), 0);
            end
            yumi_i = 1'b1;
            @(negedge clk);
            #2;
            yumi_i = 1'b0;
            chk(v_o == 1'b0 && mask_ready_o == 1'b1, "after_yumi",
                ELS*W'({v_o, mask_ready_o}), ELS*W'(2'b01));
        end
    end

    initial begin
        int t;
        reset_i  = 1'b1;
        mask_v_i = 1'b1;
        mask_i   = 16'hFFFF;
        data_v_i = 1'b1;
        data_i   = 8'h5A;
        repeat (2) @(negedge clk);
        #1;
        chk({mask_ready_o, data_ready_o, v_o} == 3'b000, "reset_state",
            ELS*W'({mask_ready_o, data_ready_o, v_o}), 0);
        chk(data_o == '0 && mask_o == '0, "reset_outputs", data_o ^ ELS*W'(mask_o), 0);
        @(negedge clk);
        reset_i  = 1'b0;
        mask_v_i = 1'b0;

        run_txn(16'h0000, 1'b0, -1);

        wq = '{8'hAA, 8'hBB};
        run_txn(16'h8001, 1'b0, -1);

        for (int i = 0; i < 16; i++) wq.push_back(W'(i));
        run_txn(16'hFFFF, 1'b0, -1);

        for (int i = 0; i < 16; i++) wq.push_back(W'(i));
        run_txn(16'hFFFF, 1'b1, -1);

        force_hold = 5;
        run_txn(ELS'($urandom), 1'b0, -1);
        run_txn(16'h0101, 1'b0, -1);

        run_txn(16'h00F0, 1'b0, 2);
        wq = '{8'h11, 8'h22};
        run_txn(16'h0030, 1'b0, -1);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0: run_txn(ELS'($urandom) & ELS'($urandom) & ELS'($urandom), 1'($urandom), -1);
                1: run_txn(ELS'(1) << $urandom_range(0, ELS - 1), 1'($urandom), -1);
                default: run_txn(ELS'($urandom), 1'($urandom), -1);
            endcase
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk(sb.size() == 0, "scoreboard_drained", ELS*W'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
